ama_riscv_line_xfer: RTL
========================

Name: ama_riscv_line_xfer

Overview:
- Cache-line transfer engine between the I/D caches and main memory.
- Converts one 512-bit line request (fill or writeback) into MEM_TRANSFERS_PER_CL 128-bit memory bus beats.
- For fills, collects the returned read beats into a full line.
- Sits directly downstream of the caches, using the common memory/cache parameters and the cache_line_data_t q[] beat layout.

Parameters:
- AW, MEM_ADDR_BUS (12), memory address width in 128-bit units
- DW, MEM_DATA_BUS (128), memory data bus width
- BEATS, MEM_TRANSFERS_PER_CL (4), beats per line; must be pow2 (build-time check with is_pow2)
- LW, DW*BEATS (512), cache line width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  cache line request valid
- req_ready  output  1  engine can accept a request
- req_we  input  1  1 = writeback line, 0 = fill line
- req_addr  input  AW  line base address in beat units; low log2(BEATS) bits ignored
- req_wdata  input  LW  writeback line data; beat k = req_wdata[k*DW +: DW]
- rsp_valid  output  1  one-cycle pulse: request complete
- rsp_we  output  1  echo of req_we for the completed request
- rsp_data  output  LW  fill line data, valid with rsp_valid when rsp_we=0
- mem_req_valid  output  1  memory beat request valid
- mem_req_ready  input  1  memory accepts beat request
- mem_req_we  output  1  beat is a write
- mem_req_addr  output  AW  beat address
- mem_req_wdata  output  DW  write beat data
- mem_rsp_valid  input  1  read beat returned (in order, no backpressure)
- mem_rsp_data  input  DW  read beat data

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high: rst asserts all state immediately, independent of clk.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_we=0, rsp_data=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0. Counters are 0.
- FSM states: IDLE, WR, RD, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch base = {req_addr[AW-1:log2(BEATS)], 0}, req_we, and req_wdata. Clear req_cnt and rsp_cnt.
  - Go to WR if req_we=1, else RD.
- WR:
  - mem_req_valid=1, mem_req_we=1, mem_req_addr=base|req_cnt, mem_req_wdata=beat[req_cnt].
  - Beat is accepted on mem_req_valid&&mem_req_ready; on acceptance req_cnt++.
  - After beat BEATS-1 is accepted, go to DONE.
  - mem_rsp_valid is ignored.
- RD:
  - mem_req_valid=1 while req_cnt<BEATS, mem_req_we=0, mem_req_addr=base|req_cnt.
  - Requests issue back-to-back, independent of responses.
  - Each mem_rsp_valid writes mem_rsp_data into line slot rsp_cnt, then rsp_cnt++.
  - A response may arrive in the same cycle as a request acceptance; both counters update.
  - After response BEATS-1 is captured, go to DONE.
  - Responses beyond BEATS are impossible by protocol; they are ignored once in DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, rsp_we=latched we.
  - rsp_data = assembled line for reads. For writes rsp_data holds its previous value.
  - req_ready=0. Next state is IDLE.
- rsp_data holds its value until the next read completion.
- mem_req_* outputs are driven from registered state (counters/latched data). They are stable while valid && !ready.
- Latency with mem_req_ready=1 and read response 1 cycle after acceptance (req accepted cycle 0):
  - Write: beats at cycles 1-4, rsp_valid at cycle 5.
  - Read: requests at cycles 1-4, responses at cycles 2-5, rsp_valid at cycle 6.
- Backpressure: mem_req_ready low stalls req_cnt only. Held beat address/data must not change.
- Address: beat addresses never cross the line, e.g. base 0xFFC issues 0xFFC..0xFFF. A misaligned req_addr such as 0x013 is treated as base 0x010.
- Counter width is log2(BEATS)+1, so the value BEATS is representable.
- Reset mid-operation returns to IDLE immediately with outputs at reset values. Memory responses arriving later in IDLE are dropped and no rsp_valid is produced.
- A req_valid arriving in DONE is not accepted. It is accepted the following IDLE cycle.

Test Plan:
- Reset then fill at req_addr=0x010, memory returns 0x11..,0x22..,0x33..,0x44.. (each 128-bit pattern) with 1-cycle latency -> mem_req_addr 0x010,0x011,0x012,0x013 on cycles 1-4; rsp_valid at cycle 6, rsp_we=0, rsp_data q[0]=0x11..,q[3]=0x44...
- Writeback at req_addr=0x020 with req_wdata q[k]=k+1, mem_req_ready=1 -> four write beats, addr 0x020..0x023, wdata 1..4; rsp_valid with rsp_we=1 at cycle 5; mem_rsp_valid pulses during WR ignored.
- Writeback with mem_req_ready toggling 0,0,1,0,1,1,0,1 -> each beat's addr/wdata held stable while stalled; exactly 4 acceptances; rsp_valid one cycle after the 4th.
- Fill at req_addr=0xFFE (misaligned, top of memory) -> base 0xFFC, beats 0xFFC..0xFFF, no wrap to 0x000.
- Fill with responses delayed 5 cycles, overlapping request issue, then req_valid held high through DONE -> line assembled in order; req_ready=0 during RD/DONE; second request accepted the cycle after rsp_valid.
- Assert rst after 2 read beats accepted, then deliver 2 late mem_rsp_valid beats -> outputs at reset values immediately; no rsp_valid; rsp_data stays 0; next request completes normally.

Source files
------------

// File: rtl/ama_riscv_line_xfer.sv
// Cache-line transfer engine: splits one line fill/writeback into BEATS memory
// bus beats and assembles returned read beats back into a full line.
module ama_riscv_line_xfer #(
  parameter int AW    = 12,
  parameter int DW    = 128,
  parameter int BEATS = 4,
  parameter int LW    = DW * BEATS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_we,
  output logic [LW-1:0] rsp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data
);

  localparam int IW = $clog2(BEATS);
  localparam int CW = IW + 1;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  generate
    if (!is_pow2(BEATS)) begin : g_beats_check
      $error("BEATS must be a power of two");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_r, state_s;
  logic [AW-1:0]             base_r, base_s;
  logic                      we_r, we_s;
  logic [BEATS-1:0][DW-1:0]  line_r, line_s;
  logic [CW-1:0]             req_cnt_r, req_cnt_s;
  logic [CW-1:0]             rsp_cnt_r, rsp_cnt_s;

  logic                      mem_req_valid_s;
  logic                      mem_req_we_s;
  logic [AW-1:0]             mem_req_addr_s;
  logic [DW-1:0]             mem_req_wdata_s;
  logic                      rsp_valid_s;
  logic                      rsp_we_s;
  logic [LW-1:0]             rsp_data_s;
  logic                      req_ready_s;
  logic                      beat_acc_s;

  // Low address bits only select a beat within the line, which the engine walks itself.
  logic                      unused_addr_bits_s;
  assign unused_addr_bits_s = ^req_addr[IW-1:0];

  // Next-state logic: request latch, beat/response counters and line assembly.
  always_comb begin
    state_s    = state_r;
    base_s     = base_r;
    we_s       = we_r;
    line_s     = line_r;
    req_cnt_s  = req_cnt_r;
    rsp_cnt_s  = rsp_cnt_r;
    beat_acc_s = mem_req_valid && mem_req_ready;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          base_s    = {req_addr[AW-1:IW], {IW{1'b0}}};
          we_s      = req_we;
          line_s    = req_wdata;
          req_cnt_s = '0;
          rsp_cnt_s = '0;
          state_s   = req_we ? WR : RD;
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        if (beat_acc_s) begin
          req_cnt_s = req_cnt_r + CW'(1);
          if (req_cnt_r == CW'(BEATS - 1)) begin
            state_s = DONE;
          end else begin
            state_s = WR;
          end
        end else begin
          state_s = WR;
        end
      end
      RD: begin
        if (beat_acc_s) begin
          req_cnt_s = req_cnt_r + CW'(1);
        end else begin
          req_cnt_s = req_cnt_r;
        end
        // Responses return in order, so rsp_cnt is the slot of the arriving beat.
        if (mem_rsp_valid) begin
          line_s[rsp_cnt_r[IW-1:0]] = mem_rsp_data;
          rsp_cnt_s = rsp_cnt_r + CW'(1);
          if (rsp_cnt_r == CW'(BEATS - 1)) begin
            state_s = DONE;
          end else begin
            state_s = RD;
          end
        end else begin
          state_s = RD;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so outputs can be flops.
  always_comb begin
    mem_req_valid_s = (state_s == WR) || ((state_s == RD) && (req_cnt_s < CW'(BEATS)));
    mem_req_we_s    = (state_s == WR);
    mem_req_addr_s  = '0;
    mem_req_wdata_s = '0;
    if (mem_req_valid_s) begin
      mem_req_addr_s = base_s | AW'(req_cnt_s[IW-1:0]);
    end else begin
      mem_req_addr_s = '0;
    end
    if (mem_req_we_s) begin
      mem_req_wdata_s = line_s[req_cnt_s[IW-1:0]];
    end else begin
      mem_req_wdata_s = '0;
    end
    rsp_valid_s = (state_s == DONE);
    req_ready_s = (state_s == IDLE);
    if (rsp_valid_s) begin
      rsp_we_s = we_s;
    end else begin
      rsp_we_s = rsp_we;
    end
    if (rsp_valid_s && !we_s) begin
      rsp_data_s = line_s;
    end else begin
      rsp_data_s = rsp_data;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      base_r        <= '0;
      we_r          <= 1'b0;
      line_r        <= '0;
      req_cnt_r     <= '0;
      rsp_cnt_r     <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_we        <= 1'b0;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      state_r       <= state_s;
      base_r        <= base_s;
      we_r          <= we_s;
      line_r        <= line_s;
      req_cnt_r     <= req_cnt_s;
      rsp_cnt_r     <= rsp_cnt_s;
      req_ready     <= req_ready_s;
      rsp_valid     <= rsp_valid_s;
      rsp_we        <= rsp_we_s;
      rsp_data      <= rsp_data_s;
      mem_req_valid <= mem_req_valid_s;
      mem_req_we    <= mem_req_we_s;
      mem_req_addr  <= mem_req_addr_s;
      mem_req_wdata <= mem_req_wdata_s;
    end
  end

endmodule
